mdu_hilo: RTL and testbench

- Parametrised multiply/divide unit with an architectural HI/LO register pair.
- Successor to the fixed 32-bit ALU-embedded mult/div path. Adds:
  - width parameter
  - configurable multiply latency
  - valid/ready issue handshake
  - flush-cancel of in-flight operations
  - MIPS32 accumulate ops (MADD/MADDU/MSUB/MSUBU)
  - direct MTHI/MTLO writes
- Sits beside the execute-stage ALU. The pipeline issues ops to it and stalls MFHI/MFLO readers while it is busy.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_hilo_if.sv | 32 +++
 rtl/mdu_div_iter.sv | 86 ++++++++
 rtl/mdu_hilo.sv | 146 ++++++++++++++
 tb/tb_mdu_hilo.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Purpose: shared opcode/state types and small decode helpers for the HI/LO multiply-divide unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MADD  = 4'd5,
    MDU_MADDU = 4'd6,
    MDU_MSUB  = 4'd7,
    MDU_MSUBU = 4'd8,
    MDU_MTHI  = 4'd9,
    MDU_MTLO  = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DIV_FIX = 2'd3
  } mdu_state_t;

  // Ops that go through the multiplier (plain and accumulating).
  function automatic logic is_mul_op(mdu_op_t op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  // Multiplier ops that treat operands as two's complement.
  function automatic logic is_signed_mul(mdu_op_t op);
    return op inside {MDU_MULT, MDU_MADD, MDU_MSUB};
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Purpose: issue/result bundle between the pipeline (master) and the HI/LO unit (slave).
// Latency: n/a (wires only).
// Backpressure: op_ready_o gates issue; stall_o tells HI/LO readers to wait.
// Ports: flush_i, op_valid_i, op_i, src_a, src_b, hilo_read_i driven by the pipeline;
//        op_ready_o, busy_o, done_o, hi_o, lo_o, stall_o driven by the unit.
interface mdu_hilo_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             flush_i;
  logic             op_valid_i;
  mdu_op_t          op_i;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hilo_read_i;
  logic             op_ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             stall_o;

  modport master (
    output flush_i, op_valid_i, op_i, src_a, src_b, hilo_read_i,
    input  op_ready_o, busy_o, done_o, hi_o, lo_o, stall_o
  );

  modport slave (
    input  flush_i, op_valid_i, op_i, src_a, src_b, hilo_read_i,
    output op_ready_o, busy_o, done_o, hi_o, lo_o, stall_o
  );

endinterface

// File: rtl/mdu_div_iter.sv
// Purpose: unsigned restoring divider core, one quotient bit per cycle.
// Latency: WIDTH cycles from start_i edge; done_o is high during the final iteration cycle.
// Backpressure: none; start_i restarts unconditionally, kill_i abandons the current division.
// Ports: clk, rst, kill_i, start_i, dividend_i, divisor_i in; quotient_o, remainder_o, done_o out.
module mdu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);

  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Partial remainder fits in WIDTH+1 bits: it is always < 2*divisor.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign done_o  = run_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (kill_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (run_q) begin
      // Borrow out of the trial subtraction means the divisor did not fit: restore.
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      if (done_o) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Purpose: multiply/divide/accumulate unit owning the architectural HI/LO pair.
// Latency: MTHI/MTLO 1 edge; mult/acc MUL_CYCLES; div WIDTH+1; divide-by-zero 1.
// Backpressure: op_ready_o low while busy; stall_o holds HI/LO readers; flush_i cancels.
// Ports: clk, rst (sync, active high) plus bus (mdu_hilo_if.slave) carrying issue and results.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mdu_hilo_if.slave  bus
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  mdu_op_t          op_q, op_d;
  logic             done_q, done_d;

  logic               accept;
  logic               div_start, div_done;
  logic [WIDTH-1:0]   mag_a, mag_b, div_quo, div_rem, quo_fix, rem_fix;
  logic               div_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res, div_res;

  assign accept = bus.op_valid_i && (state_q == ST_IDLE) && !bus.flush_i && (bus.op_i != MDU_NOP);

  // Divider sees magnitudes only; sign correction happens in DIV_FIX from the latched raw operands.
  assign mag_a = (bus.op_i == MDU_DIV && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign mag_b = (bus.op_i == MDU_DIV && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
  assign div_start = accept && (bus.op_i inside {MDU_DIV, MDU_DIVU}) && (bus.src_b != '0);

  mdu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst         (rst),
    .kill_i      (bus.flush_i),
    .start_i     (div_start),
    .dividend_i  (mag_a),
    .divisor_i   (mag_b),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  // Low 2*WIDTH bits of the product of extended operands equal the signed/unsigned product mod 2^(2W).
  assign ext_a = is_signed_mul(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = is_signed_mul(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

  always_comb begin
    mul_res = prod;
    if (op_q inside {MDU_MADD, MDU_MADDU}) mul_res = {hi_q, lo_q} + prod;
    if (op_q inside {MDU_MSUB, MDU_MSUBU}) mul_res = {hi_q, lo_q} - prod;
  end

  assign div_signed = (op_q == MDU_DIV);
  assign quo_fix = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quo : div_quo;
  assign rem_fix = (div_signed && a_q[WIDTH-1]) ? -div_rem : div_rem;
  assign div_res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = bus.op_i;
          a_d   = bus.src_a;
          b_d   = bus.src_b;
          cnt_d = '0;
          case (bus.op_i)
            MDU_MTHI: hi_d = bus.src_a;
            MDU_MTLO: lo_d = bus.src_a;
            MDU_DIV, MDU_DIVU: state_d = (bus.src_b == '0) ? ST_DIV_FIX : ST_DIV_RUN;
            default: if (is_mul_op(bus.op_i)) state_d = ST_MUL_RUN;
          endcase
        end
      end
      ST_MUL_RUN: begin
        if (cnt_q == CW'(MUL_CYCLES - 1)) begin
          {hi_d, lo_d} = mul_res;
          state_d      = ST_IDLE;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DIV_RUN: if (div_done) state_d = ST_DIV_FIX;
      ST_DIV_FIX: begin
        {hi_d, lo_d} = div_res;
        state_d      = ST_IDLE;
        done_d       = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over any commit scheduled for this edge.
    if (bus.flush_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MDU_NOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  assign bus.op_ready_o = (state_q == ST_IDLE);
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.done_o     = done_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.stall_o    = bus.busy_o && bus.hilo_read_i;

endmodule

// File: tb/tb_mdu_hilo.sv
// Purpose: directed self-checking bench for mdu_hilo at WIDTH=32, MUL_CYCLES=2.
// Latency: checks exact commit cycle for mult, div and divide-by-zero.
// Backpressure: exercises held-valid issue, flush cancel, stall and mid-op reset.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  int   pulses;

  always #5 clk = ~clk;

  mdu_hilo_if #(.WIDTH(32)) bus ();

  mdu_hilo #(.WIDTH(32), .MUL_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for exactly one cycle; returns just after the accepting edge.
  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid_i = 1'b1;
    bus.op_i       = op;
    bus.src_a      = a;
    bus.src_b      = b;
    tick();
    bus.op_valid_i = 1'b0;
    bus.op_i       = MDU_NOP;
  endtask

  // Cycles from the accepting edge until done_o is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done_o && n < 100) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [63:0] hilo();
    return {bus.hi_o, bus.lo_o};
  endfunction

  function automatic logic [63:0] flags();
    return {60'd0, bus.op_ready_o, bus.busy_o, bus.done_o, bus.stall_o};
  endfunction

  initial begin
    bus.flush_i     = 1'b0;
    bus.op_valid_i  = 1'b0;
    bus.op_i        = MDU_NOP;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.hilo_read_i = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_hilo", hilo(), 64'h0);
    chk("rst_flags", flags(), 64'h8);

    // MULT -1 * 2, cycle by cycle
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'h2);
    chk("mult_busy", flags(), 64'h4);
    tick();
    chk("mult_mid_hilo", hilo(), 64'h0);
    chk("mult_mid_flags", flags(), 64'h4);
    tick();
    chk("mult_hilo", hilo(), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mult_done", flags(), 64'hA);
    tick();
    chk("mult_done_once", flags(), 64'h8);

    // MULTU same operands
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_done(cyc);
    chk("multu_lat", 64'(cyc), 64'd2);
    chk("multu_hilo", hilo(), 64'h0000_0001_FFFF_FFFE);

    // Signed divide -7 / 2
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_done(cyc);
    chk("div_lat", 64'(cyc), 64'd33);
    chk("div_hilo", hilo(), 64'hFFFF_FFFF_FFFF_FFFD);

    // Unsigned 7 / 2
    issue(MDU_DIVU, 32'h7, 32'h2);
    wait_done(cyc);
    chk("divu_hilo", hilo(), 64'h0000_0001_0000_0003);

    // MIN / -1 wraps
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("div_min_hilo", hilo(), 64'h0000_0000_8000_0000);

    // Divide by zero
    issue(MDU_DIVU, 32'h5, 32'h0);
    wait_done(cyc);
    chk("div0_lat", 64'(cyc), 64'd1);
    chk("div0_hilo", hilo(), 64'h0000_0005_FFFF_FFFF);

    // MTHI / MTLO immediate, no done
    tick();
    issue(MDU_MTHI, 32'h0, 32'h0);
    chk("mthi_hilo", hilo(), 64'h0000_0000_FFFF_FFFF);
    issue(MDU_MTLO, 32'hFFFF_FFFF, 32'h0);
    issue(MDU_MTLO, 32'hFFFF_FFFF, 32'h0);
    chk("mtlo_flags", flags(), 64'h8);
    chk("mtlo_hilo", hilo(), 64'h0000_0000_FFFF_FFFF);

    // Accumulate ops
    issue(MDU_MADDU, 32'h1, 32'h1);
    wait_done(cyc);
    chk("maddu_hilo", hilo(), 64'h0000_0001_0000_0000);
    issue(MDU_MSUB, 32'h1, 32'h1);
    wait_done(cyc);
    chk("msub_hilo", hilo(), 64'h0000_0000_FFFF_FFFF);

    // NOP with valid is not accepted; idle read does not stall
    bus.hilo_read_i = 1'b1;
    issue(MDU_NOP, 32'h1, 32'h1);
    chk("nop_idle_flags", flags(), 64'h8);
    bus.hilo_read_i = 1'b0;

    // Flush a DIV mid-run, stall while busy
    issue(MDU_DIVU, 32'd100, 32'd3);
    repeat (8) tick();
    bus.hilo_read_i = 1'b1;
    #1;
    chk("stall_busy", flags(), 64'h5);
    bus.hilo_read_i = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flush_flags", flags(), 64'h8);
    chk("flush_hilo", hilo(), 64'h0000_0000_FFFF_FFFF);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done_o) pulses++;
    end
    chk("flush_no_done", 64'(pulses), 64'd0);

    // Op presented with flush is ignored
    bus.flush_i = 1'b1;
    issue(MDU_MTHI, 32'h1234, 32'h0);
    bus.flush_i = 1'b0;
    chk("flush_op_hilo", hilo(), 64'h0000_0000_FFFF_FFFF);

    // Flush on the would-be commit cycle of a MULT
    issue(MDU_MULT, 32'd3, 32'd3);
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flush_commit_hilo", hilo(), 64'h0000_0000_FFFF_FFFF);
    chk("flush_commit_flags", flags(), 64'h8);

    // Reset mid-DIV
    issue(MDU_DIV, 32'd100, 32'd3);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_hilo", hilo(), 64'h0);
    chk("rst_mid_flags", flags(), 64'h8);

    // Back-to-back with held valid: MULT then MADD, P = -2^32
    bus.op_valid_i = 1'b1;
    bus.op_i       = MDU_MULT;
    bus.src_a      = 32'h8000_0000;
    bus.src_b      = 32'h2;
    tick();
    bus.op_i = MDU_MADD;
    chk("b2b_held_flags", flags(), 64'h4);
    tick();
    tick();
    chk("b2b_first_hilo", hilo(), 64'hFFFF_FFFF_0000_0000);
    chk("b2b_done_ready", flags(), 64'hA);
    tick();
    bus.op_valid_i = 1'b0;
    bus.op_i       = MDU_NOP;
    chk("b2b_second_acc", flags(), 64'h4);
    wait_done(cyc);
    chk("b2b_lat", 64'(cyc), 64'd2);
    chk("b2b_final_hilo", hilo(), 64'hFFFF_FFFE_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
